// File: rtl/diff_integ.sv
// diff_integ: rebuilds NUM-lane sample beats from first-difference beats by an
// exclusive running sum, seeded per frame. Stride: i_switch=1 lag-1 chain,
// i_switch=0 two interleaved (even/odd lane) lag-2 chains.
// Optional macro DIFF_INTEG_SAT_EN: saturate on output narrowing instead of wrap.
module diff_integ #(
  parameter int unsigned SAMPLE_WIDTH = 32,
  parameter int unsigned NUM          = 8,
  parameter int unsigned GUARD        = 4,
  localparam int unsigned W           = SAMPLE_WIDTH / 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_switch,
  input  logic signed [W-1:0] i_d_data [NUM],
  input  logic                i_d_valid,
  input  logic                i_d_first,
  input  logic                i_d_last,
  input  logic signed [W-1:0] i_seed0,
  input  logic signed [W-1:0] i_seed1,
  output logic signed [W-1:0] o_x [NUM],
  output logic                o_x_valid,
  output logic                o_x_last,
  output logic                o_err
);

  localparam int unsigned CW = W + GUARD;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_accept;
  logic                 w_drop;
  logic                 r_frame_sw;

  logic                 r1_valid;
  logic                 r1_first;
  logic                 r1_last;
  logic                 r1_lag1;
  logic signed [W-1:0]  r1_d [NUM];
  logic signed [W-1:0]  r1_seed0;
  logic signed [W-1:0]  r1_seed1;

  logic signed [CW-1:0] r_ce;
  logic signed [CW-1:0] r_co;
  logic signed [CW-1:0] w_base_e;
  logic signed [CW-1:0] w_base_o;
  logic signed [CW-1:0] w_acc_e;
  logic signed [CW-1:0] w_acc_o;
  logic signed [CW-1:0] w_sum [NUM];

  logic                 r2_valid;
  logic                 r2_last;
  logic signed [CW-1:0] r2_x [NUM];

  logic signed [W-1:0]  w_nar [NUM];

  // Frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame tracking: accept beats inside a frame, drop stray beats in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_d_valid) begin
          if (i_d_first) begin
            w_accept    = 1'b1;
            w_state_nxt = i_d_last ? IDLE : RUN;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      RUN: begin
        if (i_d_valid) begin
          w_accept = 1'b1;
          if (i_d_last) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Stage 1: input register; stride is latched on the first beat only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_sw <= 1'b0;
      r1_valid   <= 1'b0;
      r1_first   <= 1'b0;
      r1_last    <= 1'b0;
      r1_lag1    <= 1'b0;
      r1_d       <= '{default: '0};
      r1_seed0   <= '0;
      r1_seed1   <= '0;
      o_err      <= 1'b0;
    end else begin
      r1_valid <= w_accept;
      r1_first <= w_accept & i_d_first;
      r1_last  <= w_accept & i_d_last;
      o_err    <= w_drop;
      if (w_accept && i_d_first) begin
        r_frame_sw <= i_switch;
        r1_seed0   <= i_seed0;
        r1_seed1   <= i_seed1;
      end
      if (w_accept) begin
        r1_lag1 <= i_d_first ? i_switch : r_frame_sw;
        r1_d    <= i_d_data;
      end
    end
  end

  // Stage 2 combinational: exclusive in-beat prefix sums on top of the carries
  always_comb begin
    w_sum    = '{default: '0};
    w_base_e = r1_first ? CW'(r1_seed0) : r_ce;
    w_base_o = r1_first ? CW'(r1_seed1) : r_co;
    w_acc_e  = w_base_e;
    w_acc_o  = w_base_o;
    for (int j = 0; j < int'(NUM); j++) begin
      if (r1_lag1 || (j % 2 == 0)) begin
        w_sum[j] = w_acc_e;
        w_acc_e  = w_acc_e + CW'(r1_d[j]);
      end else begin
        w_sum[j] = w_acc_o;
        w_acc_o  = w_acc_o + CW'(r1_d[j]);
      end
    end
  end

  // Stage 2 register: carries advance only on accepted beats, so gaps hold them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ce     <= '0;
      r_co     <= '0;
      r2_valid <= 1'b0;
      r2_last  <= 1'b0;
      r2_x     <= '{default: '0};
    end else begin
      r2_valid <= r1_valid;
      r2_last  <= r1_last;
      if (r1_valid) begin
        r_ce <= w_acc_e;
        r_co <= w_acc_o;
        r2_x <= w_sum;
      end
    end
  end

`ifdef DIFF_INTEG_SAT_EN
  localparam logic signed [CW-1:0] SAT_MAX = CW'((1 << (W - 1)) - 1);
  localparam logic signed [CW-1:0] SAT_MIN = ~SAT_MAX;

  // Stage 3 combinational: clamp the wide sum into the W-bit signed range
  always_comb begin
    w_nar = '{default: '0};
    for (int j = 0; j < int'(NUM); j++) begin
      if (r2_x[j] > SAT_MAX) begin
        w_nar[j] = W'(SAT_MAX);
      end else if (r2_x[j] < SAT_MIN) begin
        w_nar[j] = W'(SAT_MIN);
      end else begin
        w_nar[j] = W'(r2_x[j]);
      end
    end
  end
`else
  // Stage 3 combinational: keep the low W bits (modular wrap)
  always_comb begin
    w_nar = '{default: '0};
    for (int j = 0; j < int'(NUM); j++) begin
      w_nar[j] = W'(r2_x[j]);
    end
  end
`endif

  // Stage 3 register: o_x holds between valid beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_x       <= '{default: '0};
      o_x_valid <= 1'b0;
      o_x_last  <= 1'b0;
    end else begin
      o_x_valid <= r2_valid;
      o_x_last  <= r2_last;
      if (r2_valid) begin
        o_x <= w_nar;
      end
    end
  end

endmodule
